// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for a synchronous-read instruction memory.
// Issues one word-index fetch per cycle, tracks the single in-flight read,
// buffers returned words in a 2-entry queue and hands them to decode.
//
// Handshake: a transfer to decode happens on a rising edge where
// out_valid && out_ready are both high. While out_valid is high and
// out_ready is low, out_instruction/out_pc are held stable; out_valid
// never drops without a transfer except on redirect flush or reset.
module imem_fetch_ctrl #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned DEPTH    = 128,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [PC_W-1:0]    out_pc,
    output logic               fetch_err,
    output logic               dbg_state
);

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] LAST_PC    = PC_W'(DEPTH - 1);
    localparam logic [PC_W:0]   DEPTH_EXT  = (PC_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic [1:0]         count_q, count_d;
    logic [INSTR_W-1:0] q_instr_q [2];
    logic [INSTR_W-1:0] q_instr_d [2];
    logic [PC_W-1:0]    q_pc_q [2];
    logic [PC_W-1:0]    q_pc_d [2];
    logic               fetch_err_q, fetch_err_d;

    logic       pop;
    logic       push;
    logic       issue;
    logic       redir_act;
    logic       redir_bad;
    logic [2:0] occ;

    // Sequential successor inside the legal window; wraps at DEPTH, not 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return (pc == LAST_PC) ? '0 : pc + PC_W'(1);
    endfunction

    // Handshake, issue and capture decisions for this cycle.
    always_comb begin
        pop       = (count_q != 2'd0) && out_ready;
        push      = inflight_q && !redirect_valid;
        // A redirect has no effect once the sequencer has stopped on an error.
        redir_act = redirect_valid && (state_q == ST_FETCH);
        redir_bad = ({1'b0, redirect_pc} >= DEPTH_EXT);
        // Occupancy after this cycle's pop; issuing only below 2 means the
        // returned word always has a queue slot.
        occ       = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue     = (state_q == ST_FETCH) && !halt && !redirect_valid && (occ < 3'd2);
        imem_pc   = redirect_valid ? redirect_pc : fetch_pc_q;
    end

    // Next-state for queue, fetch pointer, in-flight tracker and FSM.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        q_instr_d     = q_instr_q;
        q_pc_d        = q_pc_q;
        fetch_err_d   = fetch_err_q;

        if (pop && push) begin
            if (count_q == 2'd2) begin
                q_instr_d[0] = q_instr_q[1];
                q_pc_d[0]    = q_pc_q[1];
                q_instr_d[1] = imem_instruction;
                q_pc_d[1]    = inflight_pc_q;
            end else begin
                q_instr_d[0] = imem_instruction;
                q_pc_d[0]    = inflight_pc_q;
            end
        end else if (pop) begin
            q_instr_d[0] = q_instr_q[1];
            q_pc_d[0]    = q_pc_q[1];
            count_d      = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                q_instr_d[0] = imem_instruction;
                q_pc_d[0]    = inflight_pc_q;
            end else begin
                q_instr_d[1] = imem_instruction;
                q_pc_d[1]    = inflight_pc_q;
            end
            count_d = count_q + 2'd1;
        end

        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = pc_inc(fetch_pc_q);
        end

        // Redirect: the pop above still completes, then everything is flushed.
        if (redir_act) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            if (redir_bad) begin
                fetch_err_d = 1'b1;
                state_d     = ST_HALTED;
            end else if (!halt) begin
                inflight_d    = 1'b1;
                inflight_pc_d = redirect_pc;
                fetch_pc_d    = pc_inc(redirect_pc);
            end else begin
                fetch_pc_d = redirect_pc;
            end
        end
    end

    // State registers; reset discards queue contents and any in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_FETCH;
            fetch_pc_q    <= RESET_PC_V;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= 2'd0;
            q_instr_q[0]  <= '0;
            q_instr_q[1]  <= '0;
            q_pc_q[0]     <= '0;
            q_pc_q[1]     <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            q_instr_q     <= q_instr_d;
            q_pc_q        <= q_pc_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_valid       = (count_q != 2'd0);
        out_instruction = q_instr_q[0];
        out_pc          = q_pc_q[0];
        fetch_err       = fetch_err_q;
        dbg_state       = (state_q == ST_HALTED);
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: per-cycle vector tables of inputs and
// hand-computed outputs, plus reset sequences (including async mid-stream).
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'd0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [7:0]  out_pc;
  logic        fetch_err;
  logic        dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic       ready;
    logic       halt;
    logic       rv;
    logic [7:0] rpc;
    logic       ev;
    logic [7:0] epc;
    logic       ci;
    logic [7:0] eim;
    logic       eerr;
  } vec_t;

  vec_t vecs[$];

  // clock / reset block
  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .PC_W(8), .INSTR_W(32), .DEPTH(128), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_pc(imem_pc),
    .imem_instruction(imem_instruction),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instruction(out_instruction),
    .out_pc(out_pc),
    .fetch_err(fetch_err),
    .dbg_state(dbg_state)
  );

  // synchronous-read memory: word k holds 0x1000_0000 + k
  always @(posedge clk) imem_instruction <= 32'h1000_0000 + {24'd0, imem_pc};

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic add(input logic r, input logic h, input logic rv, input logic [7:0] rpc,
                     input logic ev, input logic [7:0] epc, input logic ci,
                     input logic [7:0] eim, input logic eerr);
    vec_t v;
    v.ready = r; v.halt = h; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ci = ci; v.eim = eim; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  // called at a negedge; asserts reset asynchronously between edges
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    out_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
    #1;
    check("rst_out_valid", -1, {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", -1, {24'd0, out_pc}, 32'd0);
    check("rst_out_instr", -1, out_instruction, 32'd0);
    check("rst_imem_pc", -1, {24'd0, imem_pc}, 32'd0);
    check("rst_fetch_err", -1, {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: vector i drives the cycle before edge i+1 and states the
  // outputs expected during that cycle
  task automatic run_seg(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      out_ready = vecs[i].ready;
      halt = vecs[i].halt;
      redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc;
      #1;
      check("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        check("out_pc", i, {24'd0, out_pc}, {24'd0, vecs[i].epc});
        check("out_instr", i, out_instruction, 32'h1000_0000 + {24'd0, vecs[i].epc});
      end
      if (vecs[i].ci) check("imem_pc", i, {24'd0, imem_pc}, {24'd0, vecs[i].eim});
      check("fetch_err", i, {31'd0, fetch_err}, {31'd0, vecs[i].eerr});
      @(negedge clk);
    end
    out_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
  endtask

  initial begin
    // seg A (0..12): stream from reset, stall 4 cycles, resume
    add(1,0,0,0,   0,0,   1,0,0);
    add(1,0,0,0,   0,0,   1,1,0);
    add(1,0,0,0,   1,0,   1,2,0);
    add(1,0,0,0,   1,1,   1,3,0);
    add(1,0,0,0,   1,2,   1,4,0);
    add(0,0,0,0,   1,3,   1,5,0);
    add(0,0,0,0,   1,3,   1,5,0);
    add(0,0,0,0,   1,3,   1,5,0);
    add(0,0,0,0,   1,3,   1,5,0);
    add(1,0,0,0,   1,3,   1,5,0);
    add(1,0,0,0,   1,4,   1,6,0);
    add(1,0,0,0,   1,5,   1,7,0);
    add(1,0,0,0,   1,6,   1,8,0);
    // seg B (13..40): redirect on full queue, redirect with pop,
    // redirect under halt, wrap 126->127->0, halt 3 cycles
    add(1,0,0,0,    0,0,    1,0,0);
    add(1,0,0,0,    0,0,    1,1,0);
    add(1,0,0,0,    1,0,    1,2,0);
    add(1,0,0,0,    1,1,    1,3,0);
    add(1,0,0,0,    1,2,    1,4,0);
    add(0,0,0,0,    1,3,    1,5,0);
    add(0,0,1,8'h40,1,3,    1,8'h40,0);
    add(1,0,0,0,    0,0,    1,8'h41,0);
    add(1,0,0,0,    1,8'h40,1,8'h42,0);
    add(1,0,0,0,    1,8'h41,1,8'h43,0);
    add(1,0,1,8'h10,1,8'h42,1,8'h10,0);
    add(1,0,0,0,    0,0,    1,8'h11,0);
    add(1,0,0,0,    1,8'h10,1,8'h12,0);
    add(1,0,0,0,    1,8'h11,1,8'h13,0);
    add(1,1,1,8'h7e,1,8'h12,1,8'h7e,0);
    add(1,0,0,0,    0,0,    1,126,0);
    add(1,0,0,0,    0,0,    1,127,0);
    add(1,0,0,0,    1,126,  1,0,0);
    add(1,0,0,0,    1,127,  1,1,0);
    add(1,0,0,0,    1,0,    1,2,0);
    add(1,0,0,0,    1,1,    1,3,0);
    add(1,1,0,0,    1,2,    1,4,0);
    add(1,1,0,0,    1,3,    1,4,0);
    add(1,1,0,0,    0,0,    1,4,0);
    add(1,0,0,0,    0,0,    1,4,0);
    add(1,0,0,0,    0,0,    1,5,0);
    add(1,0,0,0,    1,4,    1,6,0);
    add(1,0,0,0,    1,5,    1,7,0);
    // seg E (41..47): out-of-range redirect while popping
    add(1,0,0,0,    0,0,    1,0,0);
    add(1,0,0,0,    0,0,    1,1,0);
    add(1,0,0,0,    1,0,    1,2,0);
    add(1,0,1,8'h90,1,1,    1,8'h90,0);
    add(1,0,0,0,    0,0,    0,0,1);
    add(1,0,0,0,    0,0,    0,0,1);
    add(1,0,0,0,    0,0,    0,0,1);

    @(negedge clk);
    do_reset();
    run_seg(0, 13);
    do_reset();
    run_seg(13, 28);
    // queue is non-empty here: async reset mid-stream, then restart at RESET_PC
    check("pre_reset_valid", -1, {31'd0, out_valid}, 32'd1);
    do_reset();
    run_seg(0, 5);
    do_reset();
    run_seg(41, 7);
    // error state must be visible on the debug output before reset
    check("halted_state", -1, {31'd0, dbg_state}, 32'd1);
    do_reset();
    check("post_reset_state", -1, {31'd0, dbg_state}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
